// File: rtl/prach_hb2_pp.sv
// Polyphase splitter ahead of the half-band decimator: pairs consecutive samples per TDM channel.
// Optional out-of-range channel drop and sticky err_chn under `define PRACH_HB2_PP_CHN_CHECK_EN.
module prach_hb2_pp #(
  parameter int NUM_CHANNEL = 32,
  parameter int CHN_W       = 8,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_dq,
  input  logic              din_dv,
  input  logic [CHN_W-1:0]  din_chn,
  input  logic              sync_in,
  output logic [DATA_W-1:0] dout_dp1,
  output logic [DATA_W-1:0] dout_dp2,
  output logic              dout_dv,
  output logic [CHN_W-1:0]  dout_chn,
  output logic              sync_out
`ifdef PRACH_HB2_PP_CHN_CHECK_EN
  ,
  output logic              err_chn
`endif
);

  localparam int IDX_W = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;

  logic [IDX_W-1:0]       idx;
  logic                   beat_ok;
  logic                   sync_ok;
  logic                   phase;
  logic                   emit;
  logic                   wr_en;
  logic [NUM_CHANNEL-1:0] ph_reg;
  logic [NUM_CHANNEL-1:0] ph_next;
  logic                   pend_reg;

  logic [DATA_W-1:0]      mem [NUM_CHANNEL];
  logic [DATA_W-1:0]      rd_data_reg;

  logic                   s1_dv_reg;
  logic [DATA_W-1:0]      s1_dq_reg;
  logic [CHN_W-1:0]       s1_chn_reg;
  logic                   s1_sync_reg;

  assign idx = din_chn[IDX_W-1:0];

`ifdef PRACH_HB2_PP_CHN_CHECK_EN
  logic chn_oor;
  assign chn_oor = (32'(din_chn) >= 32'(NUM_CHANNEL));
  // A dropped beat must not disturb anything, including a sync riding on it.
  assign beat_ok = din_dv & ~chn_oor;
  assign sync_ok = sync_in & ~(din_dv & chn_oor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_chn <= 1'b0;
    end else if (din_dv && chn_oor) begin
      err_chn <= 1'b1;
    end
  end
`else
  logic unused_chn;
  assign unused_chn = ^din_chn[CHN_W-1:IDX_W];
  assign beat_ok    = din_dv;
  assign sync_ok    = sync_in;
`endif

  // Sync clears every phase before the beat is looked at, so a sync beat is always phase 0.
  assign phase = sync_ok ? 1'b0 : ph_reg[idx];
  assign emit  = beat_ok & phase;
  assign wr_en = beat_ok & ~phase;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNEL; gi++) begin : g_ph
      assign ph_next[gi] = (beat_ok && (idx == IDX_W'(gi))) ? ~phase :
                           (sync_ok ? 1'b0 : ph_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_reg   <= '0;
      pend_reg <= 1'b0;
    end else begin
      ph_reg <= ph_next;
      if (sync_ok) begin
        pend_reg <= 1'b1;
      end else if (emit) begin
        pend_reg <= 1'b0;
      end
    end
  end

  // The read for a completing beat happens one edge after the write of its partner has
  // landed, and no single beat both writes and reads, so the read is always write-first.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= din_dq;
    end
    rd_data_reg <= mem[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_dv_reg   <= 1'b0;
      s1_dq_reg   <= '0;
      s1_chn_reg  <= '0;
      s1_sync_reg <= 1'b0;
    end else begin
      s1_dv_reg   <= emit;
      s1_sync_reg <= emit & pend_reg;
      if (emit) begin
        s1_dq_reg  <= din_dq;
        s1_chn_reg <= CHN_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_dv  <= 1'b0;
      dout_dp1 <= '0;
      dout_dp2 <= '0;
      dout_chn <= '0;
      sync_out <= 1'b0;
    end else begin
      dout_dv  <= s1_dv_reg;
      sync_out <= s1_dv_reg & s1_sync_reg;
      if (s1_dv_reg) begin
        dout_dp1 <= s1_dq_reg;
        dout_dp2 <= rd_data_reg;
        dout_chn <= s1_chn_reg;
      end
    end
  end

endmodule

// File: tb/tb_prach_hb2_pp.sv
// Directed and randomised checks of prach_hb2_pp against a small behavioural model.
// Build with +define+PRACH_HB2_PP_CHN_CHECK_EN to exercise the channel-check option.
module tb_prach_hb2_pp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din_dq = '0;
  logic        din_dv = 1'b0;
  logic [7:0]  din_chn = '0;
  logic        sync_in = 1'b0;
  logic [15:0] dout_dp1;
  logic [15:0] dout_dp2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;
`ifdef PRACH_HB2_PP_CHN_CHECK_EN
  logic        err_chn;
`endif

  prach_hb2_pp dut (
    .clk      (clk),
    .rst      (rst),
    .din_dq   (din_dq),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out)
`ifdef PRACH_HB2_PP_CHN_CHECK_EN
    ,
    .err_chn  (err_chn)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  chn;
    logic [15:0] dp2;
    logic [15:0] dp1;
    logic        sync;
  } pair_t;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    last_cyc = 0;
  pair_t obs_q[$];
  pair_t exp_q[$];

  logic [15:0] m_mem [32];
  bit          m_ph [32];
  bit          m_pend = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    pair_t p;
    if (dout_dv === 1'b1) begin
      p.cyc  = cyc;
      p.chn  = dout_chn;
      p.dp2  = dout_dp2;
      p.dp1  = dout_dp1;
      p.sync = sync_out;
      obs_q.push_back(p);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_ph[i]) m_ph[i] = 1'b0;
    m_pend = 1'b0;
  endtask

  // Drive one cycle of input and advance the reference model with the same beat.
  task automatic beat(input bit dv, input int chn, input logic [15:0] dq, input bit sync);
    bit    oor;
    int    c;
    pair_t e;
    @(negedge clk);
    din_dv   = dv;
    din_chn  = 8'(chn);
    din_dq   = dq;
    sync_in  = sync;
    last_cyc = cyc;
`ifdef PRACH_HB2_PP_CHN_CHECK_EN
    oor = (chn >= 32);
`else
    oor = 1'b0;
`endif
    c = chn % 32;
    if (sync && !(dv && oor)) begin
      foreach (m_ph[i]) m_ph[i] = 1'b0;
      m_pend = 1'b1;
    end
    if (dv && !oor) begin
      if (!m_ph[c]) begin
        m_mem[c] = dq;
        m_ph[c]  = 1'b1;
      end else begin
        e.cyc  = cyc + 2;
        e.chn  = 8'(c);
        e.dp2  = m_mem[c];
        e.dp1  = dq;
        e.sync = m_pend;
        exp_q.push_back(e);
        m_pend  = 1'b0;
        m_ph[c] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 0, 16'h0, 1'b0);
  endtask

  task automatic check_pair(input string tag, input int i, input logic [7:0] chn,
                            input logic [15:0] dp2, input logic [15:0] dp1, input logic sync);
    if (i < obs_q.size()) begin
      check(tag, {obs_q[i].chn, obs_q[i].dp2, obs_q[i].dp1, obs_q[i].sync},
            {chn, dp2, dp1, sync});
    end else begin
      check({tag, "_count"}, obs_q.size(), i + 1);
    end
  endtask

  task automatic drain();
    int n;
    check("pair_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      $display("pair cyc=%0d chn=%0d dp2=%04h dp1=%04h sync=%0b",
               obs_q[i].cyc, obs_q[i].chn, obs_q[i].dp2, obs_q[i].dp1, obs_q[i].sync);
      check("pair_cyc", obs_q[i].cyc, exp_q[i].cyc);
      check("pair_data", {obs_q[i].chn, obs_q[i].dp2, obs_q[i].dp1, obs_q[i].sync},
            {exp_q[i].chn, exp_q[i].dp2, exp_q[i].dp1, exp_q[i].sync});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
    #1;
    check("rst_async_dv", dout_dv, 1'b0);
    check("rst_async_out", {dout_dp1, dout_dp2, dout_chn, sync_out}, 41'h0);
    model_reset();
    @(negedge clk);
    check("rst_hold_out", {dout_dv, dout_dp1, dout_dp2, dout_chn, sync_out}, 42'h0);
`ifdef PRACH_HB2_PP_CHN_CHECK_EN
    check("rst_err", err_chn, 1'b0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    model_reset();
    repeat (3) @(negedge clk);
    check("init_rst_dv", dout_dv, 1'b0);
    check("init_rst_out", {dout_dp1, dout_dp2, dout_chn, sync_out}, 41'h0);
    rst = 1'b0;

    // All channels twice in order
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 32; c++) beat(1'b1, c, 16'(100 * c + pass), 1'b0);
    end
    idle(4);
    check_pair("t1_ch5", 5, 8'd5, 16'd500, 16'd501, 1'b0);
    check_pair("t1_ch31", 31, 8'd31, 16'd3100, 16'd3101, 1'b0);
    drain();

    // Same channel back to back
    beat(1'b1, 7, 16'd10, 1'b0);
    t0 = last_cyc;
    beat(1'b1, 7, 16'd11, 1'b0);
    beat(1'b1, 7, 16'd12, 1'b0);
    beat(1'b1, 7, 16'd13, 1'b0);
    idle(4);
    check_pair("t2_p0", 0, 8'd7, 16'd10, 16'd11, 1'b0);
    check_pair("t2_p1", 1, 8'd7, 16'd12, 16'd13, 1'b0);
    if (obs_q.size() >= 2) begin
      check("t2_lat0", obs_q[0].cyc, t0 + 3);
      check("t2_lat1", obs_q[1].cyc, t0 + 5);
    end
    drain();

    // Sync on a valid beat restarts the channel's pairing
    beat(1'b1, 3, 16'h1111, 1'b0);
    beat(1'b1, 3, 16'h2222, 1'b1);
    beat(1'b1, 3, 16'h3333, 1'b0);
    idle(4);
    check_pair("t3_sync", 0, 8'd3, 16'h2222, 16'h3333, 1'b1);
    drain();

    // Idle syncs twice: only the first following pair is flagged
    beat(1'b0, 0, 16'h0, 1'b1);
    beat(1'b0, 0, 16'h0, 1'b1);
    beat(1'b1, 4, 16'd1, 1'b0);
    beat(1'b1, 4, 16'd2, 1'b0);
    beat(1'b1, 4, 16'd3, 1'b0);
    beat(1'b1, 4, 16'd4, 1'b0);
    idle(4);
    check_pair("t3b_p0", 0, 8'd4, 16'd1, 16'd2, 1'b1);
    check_pair("t3b_p1", 1, 8'd4, 16'd3, 16'd4, 1'b0);
    drain();

    // Reset between the two halves of a pair
    beat(1'b1, 9, 16'h1234, 1'b0);
    do_reset();
    beat(1'b1, 9, 16'hAAAA, 1'b0);
    beat(1'b1, 9, 16'hBBBB, 1'b0);
    idle(4);
    check_pair("t4_pair", 0, 8'd9, 16'hAAAA, 16'hBBBB, 1'b0);
    drain();

`ifdef PRACH_HB2_PP_CHN_CHECK_EN
    check("t5_err_pre", err_chn, 1'b0);
    beat(1'b1, 2, 16'h5555, 1'b0);
    beat(1'b1, 40, 16'h6666, 1'b0);
    beat(1'b1, 2, 16'h7777, 1'b0);
    check("t5_err_set", err_chn, 1'b1);
    idle(4);
    check("t5_err_sticky", err_chn, 1'b1);
    check_pair("t5_pair", 0, 8'd2, 16'h5555, 16'h7777, 1'b0);
    drain();
`else
    // Channel 40 aliases onto channel 8
    beat(1'b1, 8, 16'h5555, 1'b0);
    beat(1'b1, 40, 16'h6666, 1'b0);
    idle(4);
    check_pair("t5_alias", 0, 8'd8, 16'h5555, 16'h6666, 1'b0);
    drain();
`endif

    // Random traffic with idle gaps and occasional syncs
    for (int i = 0; i < 1000; i++) begin
      bit s;
      s = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 30) begin
        beat(1'b0, 0, 16'h0, s);
      end else begin
        beat(1'b1, int'($urandom_range(0, 35)), 16'($urandom), s);
      end
    end
    idle(4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
